// File: rtl/sdram_arb_pkg.sv
// Shared types and port indices for the two-port SDRAM command arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, RD_WAIT} arb_state_t;

  // Port 0 is the display prefetch reader, port 1 the framebuffer writer.
  localparam int PORT_DISP = 0;
  localparam int PORT_GEN  = 1;

endpackage

// File: rtl/sdram_arbiter_rr_pick2.sv
// Combinational 2-way picker: urgent display reader first, otherwise
// round-robin against the last served port.
module rr_pick2
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       urgent,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  // Urgency overrides fairness; otherwise prefer the port not served last.
  always_comb begin
    any   = |req;
    grant = last;
    if (urgent && req[PORT_DISP]) grant = 1'b0;
    else if (req[~last])          grant = ~last;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the single sdram command interface between the display reader
// (port 0) and framebuffer writer (port 1). One command in flight at a time;
// ownership is held through read-data return. Every output is registered.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            m_req,
  input  logic [1:0]            m_we,
  input  logic [ADDR_WIDTH-1:0] m_addr [2],
  input  logic [DATA_WIDTH-1:0] m_data [2],
  input  logic                  m0_urgent,
  output logic [1:0]            m_ack,
  output logic [1:0]            m_valid,
  output logic [DATA_WIDTH-1:0] m_q,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  we,
  output logic                  req,
  input  logic                  ack,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] q
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t            r_state;
  logic                  r_owner;
  logic                  r_last;
  logic [CW-1:0]         r_cnt;
  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_m_ack;
  logic [1:0]            r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_q;
  logic                  r_tmo;

  logic                  w_grant;
  logic                  w_any;
  logic                  w_expired;

  rr_pick2 u_pick (
    .req    (m_req),
    .urgent (m0_urgent),
    .last   (r_last),
    .grant  (w_grant),
    .any    (w_any)
  );

  assign w_expired = (r_cnt == CNT_LAST);

  // Arbitration FSM: latch winner's command, hold req until ack, then wait
  // for read data; abandon either wait after TIMEOUT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_m_ack   <= '0;
      r_m_valid <= '0;
      r_m_q     <= '0;
      r_tmo     <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      r_m_ack   <= '0;
      r_m_valid <= '0;
      r_tmo     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_we    <= m_we[w_grant];
            r_addr  <= m_addr[w_grant];
            r_data  <= m_data[w_grant];
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= CMD;
          end
        end
        CMD: begin
          if (ack) begin
            r_req            <= 1'b0;
            r_m_ack[r_owner] <= 1'b1;
            r_cnt            <= '0;
            r_state          <= r_we ? IDLE : RD_WAIT;
          end else if (w_expired) begin
            // No m_ack: the requester keeps m_req up and retries.
            r_req   <= 1'b0;
            r_tmo   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RD_WAIT: begin
          if (valid) begin
            r_m_q              <= q;
            r_m_valid[r_owner] <= 1'b1;
            r_state            <= IDLE;
          end else if (w_expired) begin
            r_tmo   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req         = r_req;
  assign we          = r_we;
  assign addr        = r_addr;
  assign data        = r_data;
  assign m_ack       = r_m_ack;
  assign m_valid     = r_m_valid;
  assign m_q         = r_m_q;
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: write, read, round-robin, urgency,
// read/command timeouts and asynchronous reset mid-command.
module tb_sdram_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    m_req = '0;
  logic [1:0]    m_we = '0;
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  logic          m0_urgent = 1'b0;
  logic [1:0]    m_ack;
  logic [1:0]    m_valid;
  logic [DW-1:0] m_q;
  logic          timeout_err;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          we;
  logic          req;
  logic          ack = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] q = '0;

  int n_chk = 0;
  int n_err = 0;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m0_urgent   (m0_urgent),
    .m_ack       (m_ack),
    .m_valid     (m_valid),
    .m_q         (m_q),
    .timeout_err (timeout_err),
    .addr        (addr),
    .data        (data),
    .we          (we),
    .req         (req),
    .ack         (ack),
    .valid       (valid),
    .q           (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the arbiter to raise req.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(req), 32'd1);
  endtask

  // One write command from whichever port wins; port identified by address.
  task automatic cmd_wr(input int exp_port, input string tag);
    wait_req({tag, "_req"});
    chk(tag, 32'(addr), (exp_port == 1) ? 32'h0B1 : 32'h0A0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "_ack"}, 32'(m_ack), (exp_port == 1) ? 32'd2 : 32'd1);
  endtask

  // Count cycles until timeout_err, noting any m_ack / m_valid on the way.
  task automatic wait_tmo(output int k, output logic [1:0] seen_ack, output logic [1:0] seen_vld);
    k = 0;
    seen_ack = '0;
    seen_vld = '0;
    while (!timeout_err && k < 2 * TMO) begin
      tick();
      k++;
      seen_ack |= m_ack;
      seen_vld |= m_valid;
    end
  endtask

  initial begin
    int k;
    logic [1:0] sa, sv;
    m_addr[0] = '0; m_addr[1] = '0;
    m_data[0] = '0; m_data[1] = '0;

    // Reset state
    tick(); tick();
    chk("rst_req", 32'(req), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", data, 0);
    chk("rst_ack", 32'(m_ack), 0);
    chk("rst_vld", 32'(m_valid), 0);
    chk("rst_q", m_q, 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    rst_n = 1'b1;
    tick();

    // Single write from port 1, ack sampled two edges after req rises
    m_we = 2'b10; m_addr[1] = 12'h123; m_data[1] = 32'hDEADBEEF; m_req = 2'b10;
    tick();
    chk("wr_req", 32'(req), 1);
    chk("wr_addr", 32'(addr), 32'h123);
    chk("wr_data", data, 32'hDEADBEEF);
    chk("wr_we", 32'(we), 1);
    tick();
    chk("wr_req_hold", 32'(req), 1);
    chk("wr_no_early_ack", 32'(m_ack), 0);
    ack = 1'b1;
    tick();
    ack = 1'b0; m_req = 2'b00;
    chk("wr_req_drop", 32'(req), 0);
    chk("wr_ack", 32'(m_ack), 32'd2);
    chk("wr_no_vld", 32'(m_valid), 0);
    tick();
    chk("wr_ack_pulse", 32'(m_ack), 0);
    chk("wr_idle", 32'(req), 0);

    // Read from port 0; data returns 4 cycles after RD_WAIT entry
    m_we = 2'b00; m_addr[0] = 12'h010; m_req = 2'b01;
    tick();
    chk("rd_req", 32'(req), 1);
    chk("rd_addr", 32'(addr), 32'h010);
    chk("rd_we", 32'(we), 0);
    ack = 1'b1;
    tick();
    ack = 1'b0; m_req = 2'b00;
    chk("rd_ack", 32'(m_ack), 32'd1);
    tick(); tick(); tick();
    chk("rd_no_early_vld", 32'(m_valid), 0);
    valid = 1'b1; q = 32'hA5A5A5A5;
    tick();
    valid = 1'b0; q = '0;
    chk("rd_vld", 32'(m_valid), 32'd1);
    chk("rd_q", m_q, 32'hA5A5A5A5);
    tick();
    chk("rd_vld_pulse", 32'(m_valid), 0);
    // Stray valid in IDLE is ignored
    valid = 1'b1; q = 32'h12345678;
    tick();
    valid = 1'b0;
    chk("stray_vld", 32'(m_valid), 0);
    chk("stray_q", m_q, 32'hA5A5A5A5);

    // Fresh reset so port 0 wins the first tie
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Round-robin contention, all writes
    m_addr[0] = 12'h0A0; m_addr[1] = 12'h0B1;
    m_data[0] = 32'h0000_00A0; m_data[1] = 32'h0000_00B1;
    m_we = 2'b11; m_req = 2'b11;
    cmd_wr(0, "rr0");
    cmd_wr(1, "rr1");
    cmd_wr(0, "rr2");
    cmd_wr(1, "rr3");

    // Urgency: three consecutive port-0 grants, then port 1
    m0_urgent = 1'b1;
    cmd_wr(0, "urg0");
    cmd_wr(0, "urg1");
    cmd_wr(0, "urg2");
    m0_urgent = 1'b0;
    cmd_wr(1, "urg_end");
    m_req = 2'b00;
    tick();

    // Read timeout with port 1 pending behind it
    m_we = 2'b10; m_req = 2'b11;
    wait_req("tmo_rd_req");
    chk("tmo_rd_owner", 32'(addr), 32'h0A0);
    ack = 1'b1;
    tick();
    ack = 1'b0; m_req = 2'b10;
    chk("tmo_rd_ack", 32'(m_ack), 32'd1);
    wait_tmo(k, sa, sv);
    chk("tmo_rd_cycles", 32'(k), 32'(TMO));
    chk("tmo_rd_no_vld", 32'(sv), 0);
    tick();
    chk("tmo_rd_pulse", 32'(timeout_err), 0);
    chk("tmo_next_req", 32'(req), 1);
    chk("tmo_next_owner", 32'(addr), 32'h0B1);
    ack = 1'b1;
    tick();
    ack = 1'b0; m_req = 2'b00;
    chk("tmo_next_ack", 32'(m_ack), 32'd2);
    tick();

    // Command timeout: no ack ever, so no m_ack
    m_we = 2'b00; m_req = 2'b01;
    wait_req("tmo_cmd_req");
    wait_tmo(k, sa, sv);
    m_req = 2'b00;
    chk("tmo_cmd_cycles", 32'(k), 32'(TMO));
    chk("tmo_cmd_no_ack", 32'(sa), 0);
    chk("tmo_cmd_req_drop", 32'(req), 0);
    tick();

    // Asynchronous reset while in CMD
    m_we = 2'b10; m_req = 2'b10;
    wait_req("arst_req_up");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(req), 0);
    chk("arst_addr", 32'(addr), 0);
    m_req = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("arst_stray_ack", 32'(m_ack), 0);
    chk("arst_idle", 32'(req), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Backstop against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
